// File: rtl/rx_module_3_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM states and common bit periods.
package rx_module_3_pkg;

   localparam logic [12:0] Bps50M9600   = 13'd5208;
   localparam logic [12:0] Bps50M115200 = 13'd434;
   localparam logic [12:0] Bps12M9600   = 13'd1250;
   localparam logic [12:0] Bps12M115200 = 13'd104;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/rx_module_3_sync_edge.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset to 1 so the line reads idle out of reset.
module rx_module_3_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rx_i,
   output logic s1_o,
   output logic fall_o
);

   logic meta_q;
   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
      end else begin
         meta_q <= rx_i;
         s1_q   <= meta_q;
         s2_q   <= s1_q;
      end
   end

   assign s1_o   = s1_q;
   assign fall_o = s2_q & ~s1_q;

endmodule

// File: rtl/rx_module_3.sv
// 8N1 UART receiver: mid-bit sampling with a clock-count bit timer, LSB first.
// Emits a one-clock done strobe with the byte, or a one-clock framing-error strobe.
module rx_module_3
   import rx_module_3_pkg::*;
#(
   parameter logic [12:0] BPS = Bps50M115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_en_sig,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_done_sig,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam logic [12:0] HALF = BPS >> 1;

   logic        s1;
   logic        fall;
   rx_state_e   state_q;
   logic [12:0] cnt_q;
   logic [2:0]  idx_q;
   logic [7:0]  sh_q;
   logic [7:0]  rx_data_q;
   logic        done_q;
   logic        ferr_q;
   logic        busy_q;

   rx_module_3_sync_edge u_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .rx_i   (rx_pin),
      .s1_o   (s1),
      .fall_o (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         if (!rx_en_sig) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (fall) begin
                     state_q <= StStart;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               StStart: begin
                  if (cnt_q == HALF - 13'd1) begin
                     cnt_q <= '0;
                     // A start bit that is high again at its midpoint is a glitch.
                     if (!s1) begin
                        state_q <= StData;
                        idx_q   <= '0;
                     end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + 13'd1;
                  end
               end
               StData: begin
                  if (cnt_q == BPS - 13'd1) begin
                     cnt_q <= '0;
                     sh_q  <= {s1, sh_q[7:1]};
                     idx_q <= idx_q + 3'd1;
                     if (idx_q == 3'd7) begin
                        state_q <= StStop;
                     end
                  end else begin
                     cnt_q <= cnt_q + 13'd1;
                  end
               end
               StStop: begin
                  if (cnt_q == BPS - 13'd1) begin
                     // Leave at mid-stop so a start bit right after the stop bit is caught.
                     cnt_q   <= '0;
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     if (s1) begin
                        rx_data_q <= sh_q;
                        done_q    <= 1'b1;
                     end else begin
                        ferr_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + 13'd1;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_done_sig = done_q;
   assign frame_err   = ferr_q;
   assign rx_busy     = busy_q;

endmodule

// File: tb/tb_rx_module_3.sv
// Self-checking bench for rx_module_3 at 16 clocks per bit, driving the line from a serial model.
module tb_rx_module_3;

   localparam int Bps  = 16;
   localparam int Half = Bps / 2;
   // Clocks from the edge where the line falls to the edge that raises the strobe.
   localparam int Lat  = 2 + 1 + Half + 9 * Bps;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_en_sig = 1'b0;
   logic       rx_pin = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done_sig;
   logic       frame_err;
   logic       rx_busy;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int both_cnt = 0;

   int         ev_cyc[$];
   logic       ev_err[$];
   logic [7:0] ev_data[$];

   rx_module_3 #(
      .BPS (13'd16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_en_sig   (rx_en_sig),
      .rx_pin      (rx_pin),
      .rx_data     (rx_data),
      .rx_done_sig (rx_done_sig),
      .frame_err   (frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_done_sig && frame_err) both_cnt = both_cnt + 1;
         if (rx_done_sig) begin
            ev_cyc.push_back(cyc);
            ev_err.push_back(1'b0);
            ev_data.push_back(rx_data);
         end
         if (frame_err) begin
            ev_cyc.push_back(cyc);
            ev_err.push_back(1'b1);
            ev_data.push_back(rx_data);
         end
      end
   end

   task automatic clear_events();
      ev_cyc.delete();
      ev_err.delete();
      ev_data.delete();
   endtask

   // Start bit, 8 data bits LSB first, stop bit; the line is left high afterwards.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, output int t0);
      @(posedge clk); #1 rx_pin = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         repeat (Bps) @(posedge clk);
         #1 rx_pin = b[i];
      end
      repeat (Bps) @(posedge clk);
      #1 rx_pin = stop_b;
      repeat (Bps - 1) @(posedge clk);
      #1 rx_pin = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if (rx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data);
      end
      n_chk++;
      if ({rx_done_sig, frame_err, rx_busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_strobes got %b want 000", {rx_done_sig, frame_err, rx_busy});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      rx_en_sig = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_single();
      int t0;
      clear_events();
      send_frame(8'h55, 1'b1, t0);
      repeat (4) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 1) begin
         n_fail++; $display("FAIL single_count got %0d want 1", ev_cyc.size());
      end else begin
         n_chk++;
         if (ev_err[0] !== 1'b0) begin
            n_fail++; $display("FAIL single_kind got frame_err want rx_done_sig");
         end
         n_chk++;
         if (ev_cyc[0] != t0 + Lat) begin
            n_fail++; $display("FAIL single_latency got %0d want %0d", ev_cyc[0] - t0, Lat);
         end
      end
      n_chk++;
      if (rx_data !== 8'h55) begin
         n_fail++; $display("FAIL single_data got %h want 55", rx_data);
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      int t1;
      clear_events();
      send_frame(8'hA5, 1'b1, t0);
      send_frame(8'h3C, 1'b1, t1);
      repeat (4) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 2) begin
         n_fail++; $display("FAIL b2b_count got %0d want 2", ev_cyc.size());
      end else begin
         n_chk++;
         if (ev_err[0] !== 1'b0 || ev_data[0] !== 8'hA5 || ev_cyc[0] != t0 + Lat) begin
            n_fail++;
            $display("FAIL b2b_first got err=%b data=%h lat=%0d want err=0 data=a5 lat=%0d",
                     ev_err[0], ev_data[0], ev_cyc[0] - t0, Lat);
         end
         n_chk++;
         if (ev_err[1] !== 1'b0 || ev_data[1] !== 8'h3C || ev_cyc[1] != t1 + Lat) begin
            n_fail++;
            $display("FAIL b2b_second got err=%b data=%h lat=%0d want err=0 data=3c lat=%0d",
                     ev_err[1], ev_data[1], ev_cyc[1] - t1, Lat);
         end
      end
   endtask

   task automatic test_glitch();
      int t0;
      clear_events();
      @(posedge clk); #1 rx_pin = 1'b0;
      t0 = cyc;
      repeat (4) @(posedge clk);
      #1 rx_pin = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if (rx_busy !== 1'b1) begin
         n_fail++; $display("FAIL glitch_busy_early got %b want 1", rx_busy);
      end
      repeat (5) @(posedge clk); #1;
      n_chk++;
      if (rx_busy !== 1'b1) begin
         n_fail++; $display("FAIL glitch_busy_before_sample got %b want 1", rx_busy);
      end
      @(posedge clk); #1;
      n_chk++;
      if (rx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_busy_after_sample got %b want 0 at +%0d", rx_busy, cyc - t0);
      end
      repeat (40) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 0 || rx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_no_pulse got %0d pulses busy=%b want 0 pulses busy=0",
                  ev_cyc.size(), rx_busy);
      end
   endtask

   task automatic test_frame_err();
      int t0;
      clear_events();
      send_frame(8'hFF, 1'b0, t0);
      repeat (6) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 1) begin
         n_fail++; $display("FAIL ferr_count got %0d want 1", ev_cyc.size());
      end else begin
         n_chk++;
         if (ev_err[0] !== 1'b1 || ev_cyc[0] != t0 + Lat) begin
            n_fail++;
            $display("FAIL ferr_pulse got err=%b lat=%0d want err=1 lat=%0d",
                     ev_err[0], ev_cyc[0] - t0, Lat);
         end
      end
      n_chk++;
      if (rx_data !== 8'h3C) begin
         n_fail++; $display("FAIL ferr_data_held got %h want 3c", rx_data);
      end
   endtask

   task automatic test_enable_abort();
      int t0;
      int t1;
      clear_events();
      fork
         send_frame(8'h12, 1'b1, t0);
         begin
            // Lands in the middle of data bit 3.
            repeat (Bps * 4 + 7) @(posedge clk);
            #2;
            n_chk++;
            if (rx_busy !== 1'b1) begin
               n_fail++; $display("FAIL abort_busy_before got %b want 1", rx_busy);
            end
            rx_en_sig = 1'b0;
            @(posedge clk); #1;
            n_chk++;
            if (rx_busy !== 1'b0) begin
               n_fail++; $display("FAIL abort_busy_after got %b want 0", rx_busy);
            end
         end
      join
      repeat (10) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 0 || rx_data !== 8'h3C || rx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_quiet got pulses=%0d data=%h busy=%b want 0 3c 0",
                  ev_cyc.size(), rx_data, rx_busy);
      end
      rx_en_sig = 1'b1;
      repeat (4) @(posedge clk);
      send_frame(8'h81, 1'b1, t1);
      repeat (4) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 1 || rx_data !== 8'h81) begin
         n_fail++;
         $display("FAIL abort_reenable got pulses=%0d data=%h want 1 81", ev_cyc.size(), rx_data);
      end
   endtask

   task automatic test_reset_mid();
      int t0;
      int t1;
      clear_events();
      fork
         send_frame(8'($urandom_range(0, 255)), 1'b1, t0);
         begin
            repeat (60) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            n_chk++;
            if (rx_data !== 8'h00 || {rx_done_sig, frame_err, rx_busy} !== 3'b000) begin
               n_fail++;
               $display("FAIL midreset_outputs got data=%h strobes=%b want 00 000",
                        rx_data, {rx_done_sig, frame_err, rx_busy});
            end
         end
      join
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      clear_events();
      send_frame(8'h00, 1'b1, t1);
      repeat (4) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != 1) begin
         n_fail++; $display("FAIL midreset_count got %0d want 1", ev_cyc.size());
      end else begin
         n_chk++;
         if (ev_err[0] !== 1'b0 || ev_data[0] !== 8'h00 || ev_cyc[0] != t1 + Lat) begin
            n_fail++;
            $display("FAIL midreset_frame got err=%b data=%h lat=%0d want 0 00 %0d",
                     ev_err[0], ev_data[0], ev_cyc[0] - t1, Lat);
         end
      end
   endtask

   task automatic test_random();
      int         exp_cyc[$];
      logic       exp_err[$];
      logic [7:0] exp_data[$];
      logic [7:0] last_good;
      logic       prev_stop;
      logic [7:0] b;
      logic       stop_b;
      int         gap;
      int         t0;
      last_good = 8'h00;
      prev_stop = 1'b1;
      clear_events();
      for (int n = 0; n < 10; n++) begin
         b      = 8'($urandom_range(0, 255));
         stop_b = ($urandom_range(0, 3) != 0);
         gap    = $urandom_range(0, 5);
         // After a low stop bit the line must rise before the next start edge exists.
         if (!prev_stop && gap < 2) gap = 2;
         repeat (gap) @(posedge clk);
         send_frame(b, stop_b, t0);
         exp_cyc.push_back(t0 + Lat);
         exp_err.push_back(!stop_b);
         exp_data.push_back(stop_b ? b : last_good);
         if (stop_b) last_good = b;
         prev_stop = stop_b;
      end
      repeat (6) @(posedge clk); #1;
      n_chk++;
      if (ev_cyc.size() != exp_cyc.size()) begin
         n_fail++;
         $display("FAIL rand_count got %0d want %0d", ev_cyc.size(), exp_cyc.size());
      end else begin
         for (int i = 0; i < exp_cyc.size(); i++) begin
            n_chk++;
            if (ev_err[i] !== exp_err[i] || ev_data[i] !== exp_data[i] ||
                ev_cyc[i] != exp_cyc[i]) begin
               n_fail++;
               $display("FAIL rand_frame%0d got err=%b data=%h cyc=%0d want err=%b data=%h cyc=%0d",
                        i, ev_err[i], ev_data[i], ev_cyc[i], exp_err[i], exp_data[i], exp_cyc[i]);
            end
         end
      end
      n_chk++;
      if (rx_data !== last_good) begin
         n_fail++; $display("FAIL rand_last_data got %h want %h", rx_data, last_good);
      end
   endtask

   task automatic test_exclusive();
      n_chk++;
      if (both_cnt != 0) begin
         n_fail++; $display("FAIL strobes_exclusive got %0d overlaps want 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_enable_abort();
      test_reset_mid();
      test_random();
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
